// File: rtl/noise_sequencer_pkg.sv
// Shared numitron definitions: sequencer state encoding and display sizing
// constants used by the noise, sequencer and display blocks.
`timescale 1ns/1ps
package numitron_pkg;

  localparam int N_DIGITS_DEF = 8;
  localparam int SEG_W        = 7;

  typedef enum logic [1:0] {
    IDLE,
    SCRAMBLE,
    SETTLE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/noise_sequencer_if.sv
// Control/status bundle between the timebase/trigger source (master) and
// the noise sequencer (slave).
//   tick, trig, digit_mask : master -> slave
//   noise_sel, noise_en, busy, done : slave -> master
`timescale 1ns/1ps
interface noise_sequencer_if
  import numitron_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF
) ();

  logic                tick;
  logic                trig;
  logic [N_DIGITS-1:0] digit_mask;
  logic [N_DIGITS-1:0] noise_sel;
  logic                noise_en;
  logic                busy;
  logic                done;

  modport master (
    output tick, trig, digit_mask,
    input  noise_sel, noise_en, busy, done
  );

  modport slave (
    input  tick, trig, digit_mask,
    output noise_sel, noise_en, busy, done
  );

endinterface

// File: rtl/noise_sequencer_tick_timer.sv
// Tick-enable counter. Counts ticks from 0 and pulses expire on the tick
// that reaches limit, wrapping back to 0 on that same edge so it can be
// used for repeated intervals without an explicit clear.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over tick)
//   tick     : count enable
//   limit    : interval length in ticks (>= 1)
//   expire   : combinational, high on the terminal tick
`timescale 1ns/1ps
module tick_timer #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // expire must not depend on clr: callers derive clr from expire.
  assign expire = tick && (cnt_q == (limit - CNT_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = expire ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/noise_sequencer.sv
// Scramble-then-settle controller for the numitron noise datapath. On a
// manual or periodic trigger every selected digit shows LFSR noise for
// SCRAMBLE_TICKS ticks, then digits lock back to data one at a time, lowest
// index first, every STEP_TICKS ticks.
//   clk, rst : clock, async active-high reset
//   bus      : tick/trig/digit_mask in; noise_sel/noise_en/busy/done out
//
// state    | meaning
// IDLE     | waiting for trig or auto-trigger; period timer runs
// SCRAMBLE | all captured digits show noise
// SETTLE   | one digit locks to data per STEP_TICKS ticks
// DONE     | one-cycle done pulse, then back to IDLE
`timescale 1ns/1ps
module noise_sequencer
  import numitron_pkg::*;
#(
  parameter int N_DIGITS       = N_DIGITS_DEF,
  parameter int CNT_W          = 12,
  parameter int SCRAMBLE_TICKS = 200,
  parameter int STEP_TICKS     = 50,
  parameter int AUTO_PERIOD    = 0
) (
  input logic              clk,
  input logic              rst,
  noise_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] SCR_LIM  = CNT_W'(SCRAMBLE_TICKS);
  localparam logic [CNT_W-1:0] STEP_LIM = CNT_W'(STEP_TICKS);
  localparam logic [CNT_W-1:0] AUTO_LIM = CNT_W'(AUTO_PERIOD);

  seq_state_t          state_q, state_d;
  logic [N_DIGITS-1:0] sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                en_q, en_d;
  logic                done_q, done_d;

  logic             in_run;
  logic             start;
  logic             seq_clr, seq_tick, seq_exp;
  logic [CNT_W-1:0] seq_limit;
  logic             auto_clr, auto_tick, auto_exp, auto_fire;

  assign in_run = (state_q == SCRAMBLE) || (state_q == SETTLE);

  // One timer serves both run phases; the limit follows the state and the
  // count restarts from 0 on the SCRAMBLE->SETTLE edge (that tick is spent).
  assign seq_limit = (state_q == SCRAMBLE) ? SCR_LIM : STEP_LIM;
  assign seq_tick  = bus.tick && in_run;
  assign seq_clr   = !in_run || ((state_q == SCRAMBLE) && seq_exp);

  assign auto_tick = bus.tick && (state_q == IDLE);
  assign auto_fire = (AUTO_PERIOD != 0) && auto_exp;
  assign start     = (state_q == IDLE) && (bus.trig || auto_fire);
  assign auto_clr  = (state_q != IDLE) || start;

  tick_timer #(.CNT_W(CNT_W)) u_seq_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (seq_clr),
    .tick   (seq_tick),
    .limit  (seq_limit),
    .expire (seq_exp)
  );

  tick_timer #(.CNT_W(CNT_W)) u_auto_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (auto_clr),
    .tick   (auto_tick),
    .limit  (AUTO_LIM),
    .expire (auto_exp)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = bus.digit_mask;
          state_d = (bus.digit_mask == '0) ? DONE : SCRAMBLE;
        end
      end
      SCRAMBLE: begin
        if (seq_exp) state_d = SETTLE;
      end
      SETTLE: begin
        if (seq_exp) begin
          // drop the lowest set bit; masked-off digits cost no steps
          sel_d = sel_q & (sel_q - N_DIGITS'(1));
          if (sel_d == '0) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SCRAMBLE) || (state_d == SETTLE);
    en_d   = busy_d;
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign bus.noise_sel = sel_q;
  assign bus.noise_en  = en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/noise_sequencer.md
# noise_sequencer

Controller for the numitron noise datapath. On a manual or periodic trigger it runs a scramble-then-settle effect: every enabled digit shows LFSR noise for a fixed time, then the digits lock back to real display data one at a time. It drives the LFSR enable and a per-digit noise/data select consumed by the digit output mux. All timing is counted in `tick` enables from the system timebase.

## Interface
- `N_DIGITS`, default 8: number of numitron digits.
- `CNT_W`, default 12: width of every internal tick counter.
- `SCRAMBLE_TICKS`, default 200: ticks that all selected digits show noise; legal range is 1..2^CNT_W-1.
- `STEP_TICKS`, default 50: ticks between successive digit locks; legal range is 1..2^CNT_W-1.
- `AUTO_PERIOD`, default 0: idle ticks between automatic triggers. 0 disables auto-triggering.

- `clk`  in  1  system clock.
- `rst`  in  1  reset. Asynchronous and active-high.
- `tick`  in  1  single-cycle timebase enable.
- `trig`  in  1  single-cycle start request.
- `digit_mask`  in  N_DIGITS  digits that take part in the effect. Bit i corresponds to digit i.
- `noise_sel`  out  N_DIGITS  registered. 1 means digit i shows noise; 0 means it shows data.
- `noise_en`  out  1  registered. Enables the LFSR.
- `busy`  out  1  registered. High in SCRAMBLE and SETTLE.
- `done`  out  1  registered. One-cycle pulse at the end of a run.

## Operation
- The FSM has four states: IDLE, SCRAMBLE, SETTLE, DONE.
- Reset puts the FSM in IDLE and clears every counter and every output to 0. Reset takes effect immediately, including mid-run.
- **Start condition:** a start occurs in IDLE when `trig`=1 or the auto-trigger fires. A manual trigger and an auto trigger in the same cycle produce one start.
- **IDLE:**
  - On a start, `digit_mask` is captured into `noise_sel`.
  - If the captured mask is non-zero, go to SCRAMBLE with the timer cleared.
  - If the captured mask is zero, go to DONE.
- **SCRAMBLE:**
  - `noise_sel` is held.
  - The timer counts ticks.
  - On the SCRAMBLE_TICKS-th tick, go to SETTLE with the timer cleared.
- **SETTLE:**
  - On every STEP_TICKS-th tick, clear the lowest set bit of `noise_sel`. Digits therefore lock in ascending index order, and masked-off digits are skipped at no cost.
  - On the edge where that clear makes `noise_sel` zero, go to DONE.
- **DONE:** assert `done` for one cycle, then go to IDLE.
- `noise_en` = 1 exactly while the FSM is in SCRAMBLE or SETTLE.
- `trig` while not in IDLE (including DONE) is ignored and is not queued.
- `digit_mask` changes after capture have no effect on the current run.
- **Auto-trigger:**
  - The period counter counts ticks only in IDLE.
  - It clears on any start and is held at 0 outside IDLE.
  - When AUTO_PERIOD>0, it fires on the AUTO_PERIOD-th idle tick.
- A `tick` in the same cycle as a start is not counted toward SCRAMBLE.
- A `tick` on the state-transition edge from SCRAMBLE into SETTLE is consumed by SCRAMBLE. The step timer starts from 0.

## Timing
- A start at edge t gives `noise_sel`=mask, `busy`=1 and `noise_en`=1 in cycle t+1.
- SCRAMBLE lasts exactly SCRAMBLE_TICKS ticks. SETTLE lasts popcount(mask)×STEP_TICKS ticks.
- Each bit clear is visible in the cycle after its tick.
- The last clear and the deassertion of `busy`/`noise_en` are visible in the same cycle. `done` is high in that cycle only.
- Zero-mask start: `done` is high in cycle t+1, `busy` never rises, and IDLE is reached in t+2.
- The earliest accepted next `trig` is in the cycle after `done`.

## Structure
- Shared package `numitron_pkg` holds:
  - the `seq_state_t` enum (IDLE, SCRAMBLE, SETTLE, DONE);
  - `N_DIGITS_DEF` = 8;
  - the segment-width constant (7) used by the noise and display blocks.
- One sub-module, `tick_timer`, is natural. It is a CNT_W-bit counter with inputs `clr` and `tick` and a `limit` value, and it outputs a single-cycle `expire` on the tick that reaches `limit`.
- Instantiate `tick_timer` twice:
  - once shared by SCRAMBLE and SETTLE, with `limit` selected by state;
  - once for the auto period.
- Lowest-set-bit clear is `sel & (sel - 1)`. It is purely combinational and needs no priority encoder.

## Test plan
Unless stated otherwise: SCRAMBLE_TICKS=4, STEP_TICKS=2, AUTO_PERIOD=0, with a tick every 3 clocks.
- **Full mask.** `trig` with mask=8'hFF. `noise_sel`=FF, then after 4 ticks SETTLE. It then steps FE, FC, F8, F0, E0, C0, 80, 00 on every 2nd tick. `done` pulses with the final 00 and `busy` falls in that cycle.
- **Sparse mask.** `trig` with mask=8'hA5. Sequence is A5→A4→A0→80→00, taking 4 steps (8 ticks of SETTLE).
- **Zero mask.** `trig` with mask=8'h00. `done`=1 in the next cycle, `busy`/`noise_en` stay 0, and IDLE follows one cycle later.
- **Busy and capture.** Pulse `trig` during SCRAMBLE, during SETTLE and during DONE, and change `digit_mask` mid-run. The run is unaffected and no second run starts.
- **Reset mid-run.** Assert `rst` asynchronously during SETTLE with `noise_sel`=F0. All outputs are 0 immediately. After release, `trig` starts a clean run.
- **Auto-trigger.** Set AUTO_PERIOD=10 with mask=8'h0F. A run starts on the 10th idle tick and repeats 10 idle ticks after each `done`. A manual `trig` at idle tick 5 starts a run and restarts the period count.
